// File: rtl/mem_arbiter.sv
// Byte-serial memory port shared by instruction fetch and load/store buffer, one transaction at a time.
// Reads finish n+2 edges after grant, writes n edges (+1 per IO stall); rdy_in low freezes everything.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _if_req,
  input  logic [31:0] _if_addr,
  output logic        _if_done,
  output logic [31:0] _if_data,
  input  logic        _lsb_req,
  input  logic        _lsb_we,
  input  logic [1:0]  _lsb_size,
  input  logic        _lsb_signed,
  input  logic [31:0] _lsb_addr,
  input  logic [31:0] _lsb_wdata,
  output logic        _lsb_done,
  output logic [31:0] _lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_lsb_q, owner_lsb_d;
  logic        last_lsb_q, last_lsb_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic        grant_lsb, grant_stall, io_stall;
  logic [31:0] sel_addr, res;
  logic [2:0]  req_len, cnt_nx;
  logic [1:0]  idx;
  logic [7:0]  din_byte;

  assign grant_lsb   = _lsb_req && (!_if_req || !last_lsb_q);
  assign sel_addr    = grant_lsb ? _lsb_addr : _if_addr;
  assign req_len     = !grant_lsb ? 3'd4 :
                       (_lsb_size == 2'd0) ? 3'd1 :
                       (_lsb_size == 2'd1) ? 3'd2 : 3'd4;
  assign grant_stall = (sel_addr[17:16] == IO_SEL) && io_buffer_full;
  assign io_stall    = (addr_q[17:16] == IO_SEL) && io_buffer_full;
  assign cnt_nx      = cnt_q + 3'd1;
  assign idx         = cnt_q[1:0] - 2'd1;
  // The RAM keeps clocking while rdy_in is low, so the byte due at the first
  // frozen edge is parked in hold_q and consumed on the resume edge.
  assign din_byte    = hold_vld_q ? hold_q : mem_din;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic sgn);
    case (n)
      3'd1:    extend = {{24{sgn & w[7]}}, w[7:0]};
      3'd2:    extend = {{16{sgn & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_lsb_d = owner_lsb_q;
    last_lsb_d  = last_lsb_q;
    addr_d      = addr_q;
    len_d       = len_q;
    sgn_d       = sgn_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rbuf_d      = rbuf_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    res         = '0;
    case (state_q)
      IDLE: begin
        if (!_clear && (_if_req || _lsb_req)) begin
          owner_lsb_d = grant_lsb;
          last_lsb_d  = grant_lsb;
          addr_d      = sel_addr;
          len_d       = req_len;
          sgn_d       = grant_lsb & _lsb_signed;
          wdata_d     = _lsb_wdata;
          cnt_d       = 3'd0;
          rbuf_d      = '0;
          mem_a_d     = sel_addr;
          if (grant_lsb && _lsb_we) begin
            state_d    = WRITE;
            mem_dout_d = _lsb_wdata[7:0];
            mem_wr_d   = !grant_stall;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (_clear) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_nx < len_q) mem_a_d = addr_q + {29'd0, cnt_nx};
          // Capture lags the address by two edges: byte cnt-1 arrives now.
          if (cnt_q != 3'd0) rbuf_d[{idx, 3'b000} +: 8] = din_byte;
          if (cnt_q == len_q) begin
            state_d = DONE;
            res     = extend(rbuf_d, len_q, sgn_q);
            if (owner_lsb_q) begin
              lsb_rdata_d = res;
              lsb_done_d  = 1'b1;
            end else begin
              if_data_d = res;
              if_done_d = 1'b1;
            end
          end
          cnt_d = cnt_nx;
        end
      end
      WRITE: begin
        if (mem_wr_q && (cnt_q == len_q - 3'd1)) begin
          state_d    = DONE;
          lsb_done_d = 1'b1;
        end else if (mem_wr_q) begin
          cnt_d      = cnt_nx;
          mem_a_d    = addr_q + {29'd0, cnt_nx};
          mem_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
          mem_wr_d   = !io_stall;
        end else begin
          mem_wr_d = !io_stall;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      owner_lsb_q <= 1'b0;
      last_lsb_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rbuf_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      owner_lsb_q <= owner_lsb_d;
      last_lsb_q  <= last_lsb_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rbuf_q      <= rbuf_d;
      hold_vld_q  <= 1'b0;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
    end else if (!hold_vld_q) begin
      hold_q     <= mem_din;
      hold_vld_q <= 1'b1;
    end
  end

  assign _if_done   = if_done_q;
  assign _if_data   = if_data_q;
  assign _lsb_done  = lsb_done_q;
  assign _lsb_rdata = lsb_rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy_in;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory controller that shares the byte-serial RAM/IO port between the instruction fetcher and the load/store buffer. It accepts one word fetch or one sized load/store at a time and sequences the required byte transfers over the 8-bit memory bus. It assembles loaded bytes little-endian with optional sign extension and returns the result with a one-cycle done pulse. It sits between the IF/LSB back ends and the top-level `mem_*` pins.

## Interface
Parameters:
- `IO_SEL`, 2'b11: value of `addr[17:16]` marking IO space; writes there respect `io_buffer_full`.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global ready; low freezes all state.
- `_clear` in 1: pipeline flush (branch mispredict).
- `_if_req` in 1: fetch request; held with `_if_addr` stable until `_if_done`.
- `_if_addr` in 32: fetch byte address.
- `_if_done` out 1: one-cycle pulse, `_if_data` valid.
- `_if_data` out 32: fetched word.
- `_lsb_req` in 1: LSB request; held with params stable until `_lsb_done`.
- `_lsb_we` in 1: 1 = store, 0 = load.
- `_lsb_size` in 2: 0 = byte, 1 = half, 2 = word (3 treated as word).
- `_lsb_signed` in 1: sign-extend load result.
- `_lsb_addr` in 32: access byte address.
- `_lsb_wdata` in 32: store data, low bytes used.
- `_lsb_done` out 1: one-cycle pulse; load data valid or store complete.
- `_lsb_rdata` out 32: load result.
- `mem_din` in 8: RAM read data, valid the cycle after the address is sampled.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: write enable.
- `io_buffer_full` in 1: IO write buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE. The owner register records IF or LSB.
- Length n: IF = 4; LSB = 1, 2 or 4 from `_lsb_size`.
- Arbitration in IDLE:
  - One requester pending: it is granted.
  - Both pending: grant the one not granted last (round-robin bit, reset value = IF granted last, so LSB wins first).
- Grant latches addr, n, we, signed and wdata. It clears byte counter `cnt`.
  - Load/fetch goes to READ.
  - Store goes to WRITE.
- READ:
  - `mem_a` = addr + cnt for cnt = 0..n-1.
  - Byte k is captured from `mem_din` two edges after its address is driven, into bits [8k+7:8k].
  - After byte n-1 is captured, go to DONE.
- WRITE:
  - `mem_a` = addr + cnt, `mem_dout` = wdata[8cnt+7:8cnt], `mem_wr` = 1.
  - cnt advances each edge. After byte n-1, go to DONE.
  - IO stall: if addr[17:16] == IO_SEL and `io_buffer_full` = 1, force `mem_wr` = 0 and hold cnt.
- DONE:
  - Pulse the owner's done for exactly one cycle, `mem_wr` = 0.
  - Next state IDLE; no new grant is made in DONE.
- Load result: bytes above n are zero, or copies of bit 8n-1 when `_lsb_signed`. The result and `_if_data` hold until the next done of that port.
- `_clear` (sampled with `rdy_in` high):
  - READ (IF or LSB load): abort to IDLE, no done, counter reset.
  - WRITE: ignored; committed stores always complete.
  - IDLE: no grant that cycle.
  - DONE: completes normally.
- `rdy_in` low: state, counter and outputs hold; `mem_wr` output gated to 0.
- Misalignment is not checked: bytes addr..addr+n-1, 32-bit wrap-around on address add.

## Timing
- Reset (async, `rst_in` = 0): state IDLE. All outputs 0: `_if_done`, `_lsb_done`, `_if_data`, `_lsb_rdata`, `mem_a`, `mem_dout`, `mem_wr`. Round-robin bit = IF. Removing reset mid-transfer leaves no partial write pending.
- All outputs are registered.
- Read of n bytes, grant at edge E0:
  - `mem_a` = addr after E0.
  - Last byte captured at E(n+1).
  - Done high during the cycle after E(n+1).
  - Word fetch: done 6 cycles after the request is first seen in IDLE, counting the grant edge.
- Write of n bytes, grant at E0: byte k is written at edge E(k+1). Done high during the cycle after En. Each IO stall cycle adds one cycle.
- Requester drops req on the edge where done is high. Because of DONE, a re-grant is impossible in that cycle.
- Minimum spacing between transactions: 1 IDLE cycle.

## Test plan
- IF word fetch at 0x100, RAM holds 0x13 0x05 0x10 0x00 -> `_if_done` one pulse 6 cycles after req, `_if_data` = 0x00100513, `mem_wr` never high.
- LSB signed byte load at 0x200 holding 0x80, then unsigned half load at 0x200 holding 0x80 0xFF -> `_lsb_rdata` = 0xFFFFFF80, then 0x0000FF80.
- LSB word store 0xDEADBEEF at 0x300 -> `mem_wr` high 4 consecutive cycles, addresses 0x300..0x303, data EF BE AD DE, `_lsb_done` one cycle later, RAM read-back matches.
- IF and LSB requesting together and continuously -> grants alternate LSB, IF, LSB, IF; no port is starved and each done pulses once per grant.
- `_clear` asserted mid-fetch and mid-store to 0x30000 with `io_buffer_full` high for 3 cycles -> fetch aborted with no `_if_done`; store stalls 3 cycles, then completes all bytes with `_lsb_done`.
- `rdy_in` low 2 cycles mid word load, plus `rst_in` low mid-store -> load result unchanged versus no-stall run; reset immediately forces all outputs to 0 and state IDLE.
